// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic units: FSM state
// encoding, default operand geometry and the derived digit count.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;
  localparam int DEF_NDIG  = DEF_WIDTH / DEF_DIGIT;
  localparam int DEF_CNT_W = (DEF_NDIG > 1) ? $clog2(DEF_NDIG) : 1;

  // Counter width for a given digit count; never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit borrow-ripple subtractor: {bout, d} = x - y - bin.
module digit_subtractor
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  always_comb begin
    logic br;
    br = bin;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      // Borrow when x[i] is smaller than y[i] + incoming borrow.
      br   = (~x[i] & (y[i] | br)) | (y[i] & br);
    end
    bout = br;
  end

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor: DIFF = A - B - Bin, DIGIT bits per clock, with a
// start/busy/done handshake and held result registers.
module serial_subtractor32
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor32: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;
  logic [WIDTH-1:0] res_shift;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG steps.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          sa_d     = a[WIDTH-1];
          sb_d     = b[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = dig_bout;
        cnt_d    = cnt_q + 1'b1;
        // Results are captured on the last digit so they are valid during DONE.
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          state_d = ST_DONE;
          diff_d  = res_shift;
          bout_d  = dig_bout;
          ovf_d   = (sa_q ^ sb_q) & (res_shift[WIDTH-1] ^ sa_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed and randomized bench for serial_subtractor32 against an
// arithmetic reference model.
module tb_serial_subtractor32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  serial_subtractor32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, bout, diff} from plain wide arithmetic.
  function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                          input logic bi);
    logic [32:0] full;
    logic        o;
    full = {1'b0, x} - {1'b0, y} - {32'd0, bi};
    o    = (x[31] != y[31]) && (full[31] != x[31]);
    return {o, full[32], full[31:0]};
  endfunction

  // Called 1 time unit after a rising edge; returns after the accept edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ibin);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges after the accept edge until done is seen; -1 if the bound expires.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                           input logic ibin, input logic [31:0] ed, input logic eb,
                           input logic eo);
    int k;
    issue(ia, ib, ibin);
    wait_done(k);
    chk({tag, "_latency"}, 64'(k), 64'd8);
    chk({tag, "_diff"}, 64'(diff), 64'(ed));
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    int          k;
    int          pulses;
    logic [33:0] r;
    logic [31:0] ra, rb;
    logic        rbi;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_diff", 64'(diff), 64'd0);
    chk("reset_bout", 64'(bout), 64'd0);
    chk("reset_ovf",  64'(ovf),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic subtraction, then done must be a single-cycle pulse.
    run_check("basic", 32'h7000_0000, 32'h4000_0000, 1'b0, 32'h3000_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", 64'(done), 64'd0);

    // Reset during the 4th RUN cycle.
    issue(32'h1234_5678, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    chk("midrst_bout", 64'(bout), 64'd0);
    chk("midrst_ovf",  64'(ovf),  64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);
    run_check("after_rst", 32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5677, 1'b0, 1'b0);

    // Wrap-around cases.
    run_check("wrap0", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_check("wrap1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Signed overflow and adder round-trip.
    run_check("ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_check("round", 32'hE01A_0001, 32'h6606_0000, 1'b1, 32'h7A14_0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // start held high through RUN with changing operands: no restart.
    a     = 32'h0000_00F0;
    b     = 32'h0000_000F;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a   = 32'hDEAD_BEEF;
    b   = 32'h1111_1111;
    bin = 1'b1;
    k   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) start = 1'b0;
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("hold_latency", 64'(k), 64'd8);
    chk("hold_diff", 64'(diff), 64'h0000_00E1);
    chk("hold_bout", 64'(bout), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back accept in the DONE cycle; old result held until next done.
    run_check("b2b_first", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    issue(32'd5, 32'd3, 1'b0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_held_diff", 64'(diff), 64'h0000_00FF);
    wait_done(k);
    chk("b2b_latency", 64'(k), 64'd8);
    chk("b2b_diff", 64'(diff), 64'd2);

    // Random sweep against the arithmetic model.
    for (int n = 0; n < 24; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rbi = 1'($urandom_range(0, 1));
      if (n == 0) rb = ra;
      r = ref_sub(ra, rb, rbi);
      run_check("rand", ra, rb, rbi, r[31:0], r[32], r[33]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
